occ_lookup_arbiter: RTL and testbench

Shares one 256-bit AXI4 read port to the Occ table among `N_REQ` seeding engines (read-to-seed pipelines), each presenting an AXI4-Lite-style AR/R pair. Round-robin arbitration on AR; the winning requester index is encoded in ARID, and R beats are routed back by RID. The block sits between the seeding engines and the single `m_axi_*` Occ master exported to the interconnect. It also optionally limits outstanding reads per requester.

---
 rtl/occ_lookup_arbiter.sv | 165 ++++++++++++++++
 tb/tb_occ_lookup_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/occ_lookup_arbiter.sv
// Round-robin arbiter sharing one AXI4 Occ read port among N_REQ seeding engines.
// Define OCC_ARB_OUTS_LIMIT_EN to cap outstanding reads per requester at MAX_OUTS.
module occ_lookup_arbiter #(
  parameter int         N_REQ    = 4,
  parameter int         AW       = 40,
  parameter int         DW       = 256,
  parameter logic [3:0] ARID_HI  = 4'h0,
  parameter int         MAX_OUTS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ*AW-1:0]  s_araddr,
  input  logic [N_REQ*3-1:0]   s_arprot,
  input  logic [N_REQ-1:0]     s_arvalid,
  output logic [N_REQ-1:0]     s_arready,
  output logic [DW-1:0]        s_rdata,
  output logic [1:0]           s_rresp,
  output logic [N_REQ-1:0]     s_rvalid,
  input  logic [N_REQ-1:0]     s_rready,
  output logic [AW-1:0]        m_axi_araddr,
  output logic [2:0]           m_axi_arprot,
  output logic                 m_axi_arvalid,
  input  logic                 m_axi_arready,
  output logic [3:0]           m_axi_arid,
  output logic [7:0]           m_axi_arlen,
  output logic [2:0]           m_axi_arsize,
  output logic [1:0]           m_axi_arburst,
  output logic [3:0]           m_axi_arcache,
  output logic                 m_axi_arlock,
  output logic [3:0]           m_axi_arqos,
  input  logic [DW-1:0]        m_axi_rdata,
  input  logic [1:0]           m_axi_rresp,
  input  logic                 m_axi_rvalid,
  output logic                 m_axi_rready,
  input  logic [3:0]           m_axi_rid,
  input  logic                 m_axi_rlast,
  output logic                 err_rid
);

  localparam int         IDX_W    = $clog2(N_REQ);
  localparam logic [3:0] IDX_MASK = 4'((1 << IDX_W) - 1);

  logic [N_REQ-1:0] elig;
  logic             any_elig;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] rr_reg;
  logic [IDX_W-1:0] rr_next;
  logic             slot_free;
  logic             grant;
  logic             slot_valid_reg;
  logic [AW-1:0]    slot_addr_reg;
  logic [2:0]       slot_prot_reg;
  logic [IDX_W-1:0] slot_idx_reg;
  logic             err_rid_reg;
  logic [IDX_W-1:0] rid_idx;
  logic             rid_ok;
  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // First eligible requester at or after rr, scanning upward with wrap.
  always_comb begin
    any_elig = 1'b0;
    winner   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = int'(rr_reg) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (!any_elig && elig[cand_idx]) begin
        any_elig = 1'b1;
        winner   = cand_idx;
      end
    end
  end

  always_comb begin
    rr_next = rr_reg;
    if (grant) begin
      if (int'(winner) == N_REQ - 1) rr_next = '0;
      else                           rr_next = winner + IDX_W'(1);
    end
  end

  assign slot_free = !slot_valid_reg || m_axi_arready;
  // Gating with reset_n keeps s_arready low while the block is held in reset.
  assign grant     = reset_n && slot_free && any_elig;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid_reg <= 1'b0;
      slot_addr_reg  <= '0;
      slot_prot_reg  <= '0;
      slot_idx_reg   <= '0;
      rr_reg         <= '0;
      err_rid_reg    <= 1'b0;
    end else begin
      rr_reg <= rr_next;
      if (grant) begin
        slot_valid_reg <= 1'b1;
        slot_addr_reg  <= s_araddr[int'(winner)*AW +: AW];
        slot_prot_reg  <= s_arprot[int'(winner)*3 +: 3];
        slot_idx_reg   <= winner;
      end else if (m_axi_arready) begin
        slot_valid_reg <= 1'b0;
      end
      if (m_axi_rvalid && !rid_ok) err_rid_reg <= 1'b1;
    end
  end

  assign m_axi_arvalid = slot_valid_reg;
  assign m_axi_araddr  = slot_addr_reg;
  assign m_axi_arprot  = slot_prot_reg;
  assign m_axi_arid    = ARID_HI | 4'(slot_idx_reg);
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'd5;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arcache = 4'b1111;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arqos   = 4'd0;
  assign err_rid       = err_rid_reg;

  // R path is purely combinational; beats with a foreign RID are swallowed.
  assign rid_idx      = m_axi_rid[IDX_W-1:0];
  assign rid_ok       = (int'(rid_idx) < N_REQ) && ((m_axi_rid & ~IDX_MASK) == ARID_HI);
  assign m_axi_rready = rid_ok ? s_rready[rid_idx] : 1'b1;
  assign s_rdata      = m_axi_rdata;
  assign s_rresp      = m_axi_rresp;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign s_arready[gi] = grant && (int'(winner) == gi);
      assign s_rvalid[gi]  = m_axi_rvalid && rid_ok && (int'(rid_idx) == gi);

`ifdef OCC_ARB_OUTS_LIMIT_EN
      logic [3:0] cnt_reg;
      logic       inc;
      logic       dec;

      assign inc = s_arready[gi];
      assign dec = s_rvalid[gi] && s_rready[gi] && m_axi_rlast;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg <= 4'd0;
        end else if (inc && !dec) begin
          cnt_reg <= cnt_reg + 4'd1;
        end else if (dec && !inc && cnt_reg != 4'd0) begin
          cnt_reg <= cnt_reg - 4'd1;
        end
      end

      assign elig[gi] = s_arvalid[gi] && (cnt_reg < 4'(MAX_OUTS));
`else
      assign elig[gi] = s_arvalid[gi];
`endif
    end
  endgenerate

`ifndef OCC_ARB_OUTS_LIMIT_EN
  logic unused_rlast;
  assign unused_rlast = m_axi_rlast & (MAX_OUTS != 0);
`endif

endmodule

// File: tb/tb_occ_lookup_arbiter.sv
// Self-checking bench for occ_lookup_arbiter: directed scenarios plus a randomized
// run scored against a queue-based model of the arbiter.
module tb_occ_lookup_arbiter;
  localparam int N    = 4;
  localparam int AW   = 40;
  localparam int DW   = 256;
  localparam int MAXO = 2;
`ifdef OCC_ARB_OUTS_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [N*AW-1:0]   s_araddr;
  logic [N*3-1:0]    s_arprot;
  logic [N-1:0]      s_arvalid;
  logic [N-1:0]      s_arready;
  logic [DW-1:0]     s_rdata;
  logic [1:0]        s_rresp;
  logic [N-1:0]      s_rvalid;
  logic [N-1:0]      s_rready;
  logic [AW-1:0]     m_axi_araddr;
  logic [2:0]        m_axi_arprot;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [3:0]        m_axi_arid;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic [3:0]        m_axi_arcache;
  logic              m_axi_arlock;
  logic [3:0]        m_axi_arqos;
  logic [DW-1:0]     m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
  logic [3:0]        m_axi_rid;
  logic              m_axi_rlast;
  logic              err_rid;

  int tests_run = 0;
  int tests_failed = 0;

  occ_lookup_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .ARID_HI(4'h0), .MAX_OUTS(MAXO)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache),
    .m_axi_arlock(m_axi_arlock), .m_axi_arqos(m_axi_arqos), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rid(m_axi_rid), .m_axi_rlast(m_axi_rlast), .err_rid(err_rid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [2:0]    prot;
    int            idx;
  } ar_t;

  task automatic idle_inputs();
    s_araddr = '0; s_arprot = '0; s_arvalid = '0; s_rready = '0;
    m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rvalid = 1'b0; m_axi_rid = '0; m_axi_rlast = 1'b0;
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle_inputs();
    s_arvalid = '1;
    m_axi_arready = 1'b1;
    #1;
    tests_run += 9;
    if (m_axi_arvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_arvalid: got %b need 0", m_axi_arvalid); end
    if (s_arready !== 4'b0) begin tests_failed++; $display("FAIL reset_s_arready: got %b need 0000", s_arready); end
    if (err_rid !== 1'b0) begin tests_failed++; $display("FAIL reset_err_rid: got %b need 0", err_rid); end
    if (m_axi_arlen !== 8'd0) begin tests_failed++; $display("FAIL arlen: got %0d need 0", m_axi_arlen); end
    if (m_axi_arsize !== 3'd5) begin tests_failed++; $display("FAIL arsize: got %0d need 5", m_axi_arsize); end
    if (m_axi_arburst !== 2'b01) begin tests_failed++; $display("FAIL arburst: got %b need 01", m_axi_arburst); end
    if (m_axi_arcache !== 4'b1111) begin tests_failed++; $display("FAIL arcache: got %b need 1111", m_axi_arcache); end
    if (m_axi_arlock !== 1'b0) begin tests_failed++; $display("FAIL arlock: got %b need 0", m_axi_arlock); end
    if (m_axi_arqos !== 4'd0) begin tests_failed++; $display("FAIL arqos: got %0d need 0", m_axi_arqos); end
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b1;
    #1;
    tests_run++;
    if (m_axi_arvalid !== 1'b0) begin tests_failed++; $display("FAIL post_reset_arvalid: got %b need 0", m_axi_arvalid); end
    $display("[TB] reset checked");
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_sr;
    apply_reset();
    s_arvalid = '1;
    m_axi_arready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      exp_sr = 4'(1 << (k % N));
      tests_run += 2;
      if (s_arready !== exp_sr) begin tests_failed++; $display("FAIL fair_grant[%0d]: got %b need %b", k, s_arready, exp_sr); end
      if (k == 0) begin
        if (m_axi_arvalid !== 1'b0) begin tests_failed++; $display("FAIL fair_first_arvalid: got %b need 0", m_axi_arvalid); end
      end else begin
        if (m_axi_arvalid !== 1'b1 || m_axi_arid !== 4'((k - 1) % N)) begin
          tests_failed++;
          $display("FAIL fair_arid[%0d]: got valid=%b id=%0d need valid=1 id=%0d", k, m_axi_arvalid, m_axi_arid, (k - 1) % N);
        end
        $display("[TB] fairness AR id=%0d", m_axi_arid);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_stall_hold();
    apply_reset();
    s_arvalid = 4'b0100;
    s_araddr[2*AW +: AW] = 40'h12_3456_7800;
    s_arprot[2*3 +: 3] = 3'b010;
    #1;
    tests_run++;
    if (s_arready !== 4'b0100) begin tests_failed++; $display("FAIL stall_first_accept: got %b need 0100", s_arready); end
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      tests_run += 2;
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 40'h12_3456_7800 || m_axi_arid !== 4'd2 || m_axi_arprot !== 3'b010) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got v=%b a=%h id=%0d need v=1 a=1234567800 id=2", k, m_axi_arvalid, m_axi_araddr, m_axi_arid);
      end
      if (s_arready !== 4'b0000) begin tests_failed++; $display("FAIL stall_sready[%0d]: got %b need 0000", k, s_arready); end
      @(negedge clk);
    end
    m_axi_arready = 1'b1;
    #1;
    tests_run++;
    if (s_arready !== 4'b0100 || m_axi_arvalid !== 1'b1) begin
      tests_failed++; $display("FAIL stall_release: got sready=%b v=%b need 0100 v=1", s_arready, m_axi_arvalid);
    end
    $display("[TB] stall AR id=%0d addr=%h accepted", m_axi_arid, m_axi_araddr);
    @(negedge clk);
    s_arvalid = '0;
    #1;
    tests_run++;
    if (m_axi_arvalid !== 1'b1 || m_axi_arid !== 4'd2) begin tests_failed++; $display("FAIL stall_reload: got v=%b id=%0d need v=1 id=2", m_axi_arvalid, m_axi_arid); end
    @(negedge clk);
    #1;
    tests_run++;
    if (m_axi_arvalid !== 1'b0) begin tests_failed++; $display("FAIL stall_drain: got %b need 0", m_axi_arvalid); end
    idle_inputs();
  endtask

  task automatic test_r_routing();
    logic [DW-1:0] pat;
    apply_reset();
    pat = {32{8'hA5}};
    m_axi_rvalid = 1'b1; m_axi_rid = 4'd3; m_axi_rdata = pat; m_axi_rresp = 2'b10; m_axi_rlast = 1'b1;
    s_rready = 4'b0111;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests_run += 2;
      if (s_rvalid !== 4'b1000 || m_axi_rready !== 1'b0) begin
        tests_failed++; $display("FAIL r_hold[%0d]: got rvalid=%b rready=%b need 1000 0", k, s_rvalid, m_axi_rready);
      end
      if (s_rdata !== pat || s_rresp !== 2'b10) begin tests_failed++; $display("FAIL r_data[%0d]: got %h/%b need a5../10", k, s_rdata, s_rresp); end
      @(negedge clk);
    end
    s_rready = 4'b1000;
    #1;
    tests_run++;
    if (s_rvalid !== 4'b1000 || m_axi_rready !== 1'b1) begin
      tests_failed++; $display("FAIL r_complete: got rvalid=%b rready=%b need 1000 1", s_rvalid, m_axi_rready);
    end
    $display("[TB] R beat rid=3 delivered");
    @(negedge clk);
    m_axi_rvalid = 1'b0;
    #1;
    tests_run += 2;
    if (s_rvalid !== 4'b0000) begin tests_failed++; $display("FAIL r_idle: got %b need 0000", s_rvalid); end
    if (err_rid !== 1'b0) begin tests_failed++; $display("FAIL r_no_err: got %b need 0", err_rid); end
    idle_inputs();
  endtask

  task automatic test_bad_rid();
    apply_reset();
    m_axi_rvalid = 1'b1; m_axi_rid = 4'h7; s_rready = 4'b0000;
    #1;
    tests_run += 3;
    if (m_axi_rready !== 1'b1) begin tests_failed++; $display("FAIL bad_rid_rready: got %b need 1", m_axi_rready); end
    if (s_rvalid !== 4'b0000) begin tests_failed++; $display("FAIL bad_rid_rvalid: got %b need 0000", s_rvalid); end
    if (err_rid !== 1'b0) begin tests_failed++; $display("FAIL bad_rid_err_early: got %b need 0", err_rid); end
    @(negedge clk);
    m_axi_rvalid = 1'b0; m_axi_rid = 4'h0;
    #1;
    tests_run++;
    if (err_rid !== 1'b1) begin tests_failed++; $display("FAIL bad_rid_err_set: got %b need 1", err_rid); end
    @(negedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if (err_rid !== 1'b1) begin tests_failed++; $display("FAIL bad_rid_err_sticky: got %b need 1", err_rid); end
    $display("[TB] bad RID 7 dropped");
    idle_inputs();
  endtask

  task automatic test_async_reset();
    apply_reset();
    s_arvalid = 4'b0100;
    #1;
    @(negedge clk);
    #1;
    tests_run++;
    if (m_axi_arvalid !== 1'b1) begin tests_failed++; $display("FAIL areset_pre: got %b need 1", m_axi_arvalid); end
    #2;
    reset_n = 1'b0;
    #1;
    tests_run += 2;
    if (m_axi_arvalid !== 1'b0) begin tests_failed++; $display("FAIL areset_arvalid: got %b need 0", m_axi_arvalid); end
    if (s_arready !== 4'b0000) begin tests_failed++; $display("FAIL areset_sready: got %b need 0000", s_arready); end
    @(negedge clk);
    s_arvalid = '1;
    reset_n = 1'b1;
    #1;
    tests_run++;
    if (s_arready !== 4'b0001) begin tests_failed++; $display("FAIL areset_first_grant: got %b need 0001", s_arready); end
    m_axi_arready = 1'b1;
    @(negedge clk);
    s_arvalid = '0;
    #1;
    tests_run++;
    if (m_axi_arvalid !== 1'b1 || m_axi_arid !== 4'd0) begin tests_failed++; $display("FAIL areset_first_id: got v=%b id=%0d need v=1 id=0", m_axi_arvalid, m_axi_arid); end
    $display("[TB] async reset AR id=%0d", m_axi_arid);
    idle_inputs();
  endtask

`ifdef OCC_ARB_OUTS_LIMIT_EN
  task automatic test_outs_limit();
    logic [N-1:0] exp_sr [6];
    logic [N-1:0] req    [6];
    exp_sr = '{4'b0001, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0001};
    req    = '{4'b0001, 4'b0001, 4'b0011, 4'b0001, 4'b0001, 4'b0001};
    apply_reset();
    m_axi_arready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      s_arvalid = req[k];
      m_axi_rvalid = (k == 4);
      m_axi_rid = 4'd0; m_axi_rlast = 1'b1; s_rready = 4'b0001;
      #1;
      tests_run++;
      if (s_arready !== exp_sr[k]) begin tests_failed++; $display("FAIL outs_limit[%0d]: got %b need %b", k, s_arready, exp_sr[k]); end
      $display("[TB] limit step %0d sready=%b", k, s_arready);
      @(negedge clk);
    end
    idle_inputs();
  endtask
`endif

  task automatic test_random();
    bit            pend [N];
    logic [AW-1:0] paddr [N];
    logic [2:0]    pprot [N];
    int            outs [N];
    int            rr_m;
    int            w;
    int            c;
    int            cands [$];
    bit            exp_free;
    logic [N-1:0]  exp_sr;
    ar_t           q [$];
    ar_t           e;
    apply_reset();
    rr_m = 0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; outs[i] = 0; paddr[i] = '0; pprot[i] = '0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          paddr[i] = {8'($urandom), $urandom};
          pprot[i] = 3'($urandom);
        end
        s_arvalid[i] = pend[i];
        s_araddr[i*AW +: AW] = paddr[i];
        s_arprot[i*3 +: 3] = pprot[i];
      end
      m_axi_arready = ($urandom_range(0, 3) != 0);
      cands.delete();
      for (int i = 0; i < N; i++) if (outs[i] > 0) cands.push_back(i);
      m_axi_rvalid = (cands.size() > 0) && ($urandom_range(0, 1) == 1);
      m_axi_rid = m_axi_rvalid ? 4'(cands[$urandom_range(0, cands.size() - 1)]) : 4'($urandom_range(0, N - 1));
      m_axi_rlast = 1'($urandom);
      m_axi_rdata = {8{$urandom}};
      s_rready = 4'($urandom);
      #1;
      exp_free = (q.size() == 0) || m_axi_arready;
      w = -1;
      for (int off = 0; off < N; off++) begin
        c = (rr_m + off) % N;
        if (w < 0 && pend[c] && (!LIMIT_EN || outs[c] < MAXO)) w = c;
      end
      exp_sr = (exp_free && w >= 0) ? 4'(1 << w) : 4'b0;
      tests_run += 4;
      if (s_arready !== exp_sr) begin tests_failed++; $display("FAIL rand_sready[%0d]: got %b need %b", cyc, s_arready, exp_sr); end
      if (m_axi_arvalid !== (q.size() != 0)) begin tests_failed++; $display("FAIL rand_arvalid[%0d]: got %b need %b", cyc, m_axi_arvalid, q.size() != 0); end
      if (s_rvalid !== (m_axi_rvalid ? 4'(1 << m_axi_rid) : 4'b0)) begin tests_failed++; $display("FAIL rand_rvalid[%0d]: got %b rid=%0d", cyc, s_rvalid, m_axi_rid); end
      if (m_axi_rready !== s_rready[m_axi_rid[1:0]]) begin tests_failed++; $display("FAIL rand_rready[%0d]: got %b need %b", cyc, m_axi_rready, s_rready[m_axi_rid[1:0]]); end
      if (q.size() != 0) begin
        tests_run++;
        if (m_axi_araddr !== q[0].addr || m_axi_arprot !== q[0].prot || m_axi_arid !== 4'(q[0].idx)) begin
          tests_failed++;
          $display("FAIL rand_ar[%0d]: got a=%h p=%0d id=%0d need a=%h p=%0d id=%0d", cyc, m_axi_araddr, m_axi_arprot, m_axi_arid, q[0].addr, q[0].prot, q[0].idx);
        end
        if (m_axi_arready) begin
          $display("[TB] AR id=%0d addr=%h", m_axi_arid, m_axi_araddr);
          void'(q.pop_front());
        end
      end
      if (exp_free && w >= 0) begin
        e.addr = paddr[w]; e.prot = pprot[w]; e.idx = w;
        q.push_back(e);
        pend[w] = 0;
        rr_m = (w + 1) % N;
        outs[w]++;
      end
      if (m_axi_rvalid && s_rready[m_axi_rid[1:0]] && m_axi_rlast && outs[m_axi_rid] > 0) outs[m_axi_rid]--;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fairness();
    test_stall_hold();
    test_r_routing();
    test_bad_rid();
    test_async_reset();
`ifdef OCC_ARB_OUTS_LIMIT_EN
    test_outs_limit();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
